pcm_to_i2s: RTL

Transmit-side counterpart of the microphone receive path. Accepts 16-bit mono PCM samples on an AXI-stream slave, buffers them in a small FIFO, and serialises each sample onto a standard Philips I2S link (bclk, lrclk, sdata) for an external DAC or amplifier. bclk is derived from the single system clock by an even integer divider. The same sample is sent in both the left and right slots.

---
 rtl/pcm_to_i2s.sv | 133 +++++++++++++
 1 files changed

// File: rtl/pcm_to_i2s.sv
// PCM-to-I2S transmitter: an AXI-stream sample FIFO feeding a Philips I2S serialiser.
// Each 16-bit mono sample is sent in both the left and the right 32-bit slot.
module pcm_to_i2s #(
  parameter int unsigned BCLK_DIV    = 4,
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned START_LEVEL = 2
) (
  input  logic                   clk,
  input  logic                   arst,
  input  logic                   en,
  input  logic [15:0]            s_tdata,
  input  logic                   s_tvalid,
  output logic                   s_tready,
  output logic                   bclk,
  output logic                   lrclk,
  output logic                   sdata,
  output logic                   underrun,
  output logic [$clog2(DEPTH):0] fifo_level
);
  localparam int unsigned AddrW = $clog2(DEPTH);
  localparam int unsigned LvlW  = AddrW + 1;
  localparam int unsigned DivW  = $clog2(BCLK_DIV);

  localparam logic [DivW-1:0] DivLast  = DivW'(BCLK_DIV - 1);
  localparam logic [DivW-1:0] DivHalf  = DivW'(BCLK_DIV / 2);
  localparam logic [LvlW-1:0] LvlFull  = LvlW'(DEPTH);
  localparam logic [LvlW-1:0] LvlStart = LvlW'(START_LEVEL);

  typedef enum logic [1:0] {StIdle, StPrime, StRun} state_e;

  state_e            state_q, state_d;
  logic [DivW-1:0]   div_q, div_d;
  logic [5:0]        bit_q, bit_d;
  logic [AddrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [LvlW-1:0]   level_q, level_d;
  logic [15:0]       mem_q [DEPTH];
  logic [15:0]       frame_q, frame_d;
  logic              bclk_q, bclk_d;
  logic              lrclk_q, lrclk_d;
  logic              sdata_q, sdata_d;
  logic              push, pop, load, fifo_empty, run_d;
  logic [4:0]        pos_d;
  logic [3:0]        sel_d;

  always_comb begin
    fifo_empty = (level_q == '0);
    s_tready   = (level_q != LvlFull);
    push       = s_tvalid && s_tready;
    load       = 1'b0;
    state_d    = state_q;
    div_d      = '0;
    bit_d      = '0;

    unique case (state_q)
      StIdle: begin
        if (en) state_d = StPrime;
      end
      StPrime: begin
        if (en && level_q >= LvlStart) begin
          state_d = StRun;
          load    = 1'b1;
        end
      end
      StRun: begin
        if (en) begin
          div_d = (div_q == DivLast) ? '0 : div_q + DivW'(1);
          bit_d = (div_q == DivLast) ? bit_q + 6'd1 : bit_q;
          load  = (div_q == DivLast) && (bit_q == 6'd63);
        end
      end
      default: state_d = StIdle;
    endcase
    if (!en) state_d = StIdle;

    // A load always pops the old head; a same-cycle push lands behind it.
    pop      = load && !fifo_empty;
    underrun = load && fifo_empty;

    case ({push, pop})
      2'b10:   level_d = level_q + LvlW'(1);
      2'b01:   level_d = level_q - LvlW'(1);
      default: level_d = level_q;
    endcase

    frame_d = frame_q;
    if (load) frame_d = fifo_empty ? 16'h0000 : mem_q[rd_ptr_q];

    // Outputs are registered for the upcoming counter values.
    run_d   = (state_d == StRun);
    pos_d   = bit_d[4:0];
    sel_d   = 4'(5'd16 - pos_d);
    bclk_d  = run_d && (div_d >= DivHalf);
    lrclk_d = run_d && bit_d[5];
    sdata_d = 1'b0;
    if (run_d && pos_d >= 5'd1 && pos_d <= 5'd16) sdata_d = frame_q[sel_d];
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_q  <= StIdle;
      div_q    <= '0;
      bit_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      frame_q  <= '0;
      bclk_q   <= 1'b0;
      lrclk_q  <= 1'b0;
      sdata_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      bit_q    <= bit_d;
      level_q  <= level_d;
      frame_q  <= frame_d;
      bclk_q   <= bclk_d;
      lrclk_q  <= lrclk_d;
      sdata_q  <= sdata_d;
      if (push) wr_ptr_q <= wr_ptr_q + AddrW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AddrW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= s_tdata;
  end

  assign bclk       = bclk_q;
  assign lrclk      = lrclk_q;
  assign sdata      = sdata_q;
  assign fifo_level = level_q;

endmodule
